// File: rtl/conv2d_stream.sv
// Streaming KxK 2-D convolution: kernel load, raster pixel stream through line buffers,
// two-stage multiply / sum-shift-clip pipeline with fixed-latency strobe and frame-done pulse.
module conv2d_stream #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16,
  parameter int SHIFT       = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] kernel_in,
  input  logic            kernel_valid,
  output logic            kernel_ready,
  input  logic            kernel_reload,
  input  logic [BITS-1:0] pix_in,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_valid,
  output logic            frame_done
);
  localparam int K      = KERNEL_SIZE;
  localparam int KK     = K * K;
  localparam int KW     = $clog2(KK);
  localparam int CW     = $clog2(IMG_WIDTH);
  localparam int RW     = $clog2(IMG_HEIGHT);
  localparam int PW     = 2 * BITS + 1;
  localparam int ACC    = PW + $clog2(KK);
  localparam int STAGES = 2;
  localparam logic signed [ACC-1:0] MAXV = ACC'((1 << BITS) - 1);

  typedef enum logic {KLOAD, STREAM} state_t;

  state_t                 r_state;
  logic [KW-1:0]          r_kidx;
  logic [CW-1:0]          r_col;
  logic [RW-1:0]          r_row;
  logic signed [BITS-1:0] r_kern [KK];
  logic [STAGES:0]        r_vld_pipe;
  logic [STAGES:0]        r_last_pipe;
  logic [BITS-1:0]        r_out;
  logic [BITS-1:0]        r_lb   [K-1][IMG_WIDTH];
  logic [BITS-1:0]        r_win  [K][K];
  logic signed [PW-1:0]   r_prod [KK];

  logic                   w_acc, w_abort, w_trig, w_col_last, w_row_last;
  logic signed [ACC-1:0]  w_sum, w_shr;
  logic [BITS-1:0]        w_clip;

  assign kernel_ready = (r_state == KLOAD);
  assign pix_ready    = (r_state == STREAM);
  assign w_abort      = pix_ready && kernel_reload;
  assign w_acc        = pix_ready && pix_valid;
  assign w_col_last   = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_last   = (r_row == RW'(IMG_HEIGHT - 1));
  // Only fully-inside window positions produce a result; this gating also hides stale line data.
  assign w_trig       = w_acc && !kernel_reload && (r_row >= RW'(K - 1)) && (r_col >= CW'(K - 1));

  assign out_valid    = r_vld_pipe[STAGES];
  assign frame_done   = r_last_pipe[STAGES];
  assign out_data     = r_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= KLOAD;
      r_kidx      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_out       <= '0;
      for (int n = 0; n < KK; n++) r_kern[n] <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[STAGES-1:0], w_trig};
      r_last_pipe <= {r_last_pipe[STAGES-1:0], w_trig && w_row_last && w_col_last};
      if (r_vld_pipe[STAGES-1] && !w_abort) r_out <= w_clip;
      case (r_state)
        KLOAD: if (kernel_valid) begin
          r_kern[r_kidx] <= $signed(kernel_in);
          if (r_kidx == KW'(KK - 1)) begin
            r_kidx  <= '0;
            r_state <= STREAM;
          end else begin
            r_kidx <= r_kidx + 1'b1;
          end
        end
        STREAM: if (kernel_reload) begin
          // Abort: in-flight results are squashed so no strobe follows the reload.
          r_state     <= KLOAD;
          r_col       <= '0;
          r_row       <= '0;
          r_vld_pipe  <= '0;
          r_last_pipe <= '0;
        end else if (pix_valid) begin
          if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
      endcase
    end
  end

  // Line buffers hold rows r-K+1..r-1 per column; the window shifts left and takes a new column.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K - 1; j++) r_win[i][j] <= r_win[i][j+1];
      for (int i = 0; i < K - 1; i++) r_win[i][K-1] <= r_lb[i][r_col];
      for (int i = 0; i < K - 2; i++) r_lb[i][r_col] <= r_lb[i+1][r_col];
      r_lb[K-2][r_col]  <= pix_in;
      r_win[K-1][K-1]   <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        r_prod[i*K+j] <= PW'($signed({1'b0, r_win[i][j]})) * PW'(r_kern[(K-1-i)*K + (K-1-j)]);
  end

  always_comb begin
    w_sum = '0;
    for (int n = 0; n < KK; n++) w_sum = w_sum + ACC'(r_prod[n]);
    w_shr = w_sum >>> SHIFT;
    if (w_shr[ACC-1])       w_clip = '0;
    else if (w_shr > MAXV)  w_clip = '1;
    else                    w_clip = w_shr[BITS-1:0];
  end
endmodule
